// File: rtl/hms_watch_cnt_if.sv
// hms_watch_cnt_if -- button/tick inputs and time-of-day outputs of the watch core.
//   i_tick     1-cycle 1 Hz pulse (synchronous to clk)
//   i_sw_mode  raw mode-toggle button
//   i_sw_pos   raw field-select button
//   i_sw_inc   raw field-increment button
//   o_sec/o_min/o_hour  6-bit time fields
//   o_mode     0 = CLOCK, 1 = SETUP
//   o_pos      selected field (0 SEC, 1 MIN, 2 HOUR)
//   o_six_dp   decimal-point enables for the six digits
interface hms_watch_cnt_if;
  logic       i_tick;
  logic       i_sw_mode;
  logic       i_sw_pos;
  logic       i_sw_inc;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [5:0] o_hour;
  logic       o_mode;
  logic [1:0] o_pos;
  logic [5:0] o_six_dp;

  modport master (
    output i_tick, i_sw_mode, i_sw_pos, i_sw_inc,
    input  o_sec, o_min, o_hour, o_mode, o_pos, o_six_dp
  );

  modport slave (
    input  i_tick, i_sw_mode, i_sw_pos, i_sw_inc,
    output o_sec, o_min, o_hour, o_mode, o_pos, o_six_dp
  );
endinterface

// File: rtl/hms_watch_cnt.sv
// hms_watch_cnt -- hours/minutes/seconds core for the six-digit FND clock.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    hms_watch_cnt_if.slave: tick + three raw buttons in, time/mode/pos/DP out
// CLOCK mode advances on i_tick with full carry; SETUP mode freezes time and lets
// the pos/inc buttons edit one field at a time (wrap without carry).
module hms_watch_cnt #(
  parameter int unsigned SEC_MAX  = 59,
  parameter int unsigned MIN_MAX  = 59,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  hms_watch_cnt_if.slave  bus
);
  localparam int unsigned NUM_BTN = 3;
  localparam logic [5:0] SEC_MAX_V  = 6'(SEC_MAX);
  localparam logic [5:0] MIN_MAX_V  = 6'(MIN_MAX);
  localparam logic [5:0] HOUR_MAX_V = 6'(HOUR_MAX);

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  typedef enum logic {ST_CLOCK = 1'b0, ST_SETUP = 1'b1} state_e;

  // Button conditioning: per button {hist, sync2, sync1}; press = rising edge of sync2.
  logic [NUM_BTN-1:0]      btn_raw;
  logic [NUM_BTN-1:0][2:0] sync_q;
  logic [NUM_BTN-1:0]      press;

  assign btn_raw = {bus.i_sw_inc, bus.i_sw_pos, bus.i_sw_mode};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q[b] <= 3'b000;
      else        sync_q[b] <= {sync_q[b][1], sync_q[b][0], btn_raw[b]};
    end
    assign press[b] = sync_q[b][1] & ~sync_q[b][2];
  end

  logic mode_p, pos_p, inc_p;
  assign mode_p = press[0];
  assign pos_p  = press[1];
  assign inc_p  = press[2];

  state_e     state_q;
  logic [5:0] sec_q, min_q, hour_q;
  logic [1:0] pos_q;

  // Wrapped increments shared by tick carry chain and SETUP edits.
  logic       sec_wrap, min_wrap;
  logic [5:0] sec_d, min_d, hour_d;
  assign sec_wrap = (sec_q == SEC_MAX_V);
  assign min_wrap = (min_q == MIN_MAX_V);
  assign sec_d    = sec_wrap ? 6'd0 : sec_q + 6'd1;
  assign min_d    = min_wrap ? 6'd0 : min_q + 6'd1;
  assign hour_d   = (hour_q == HOUR_MAX_V) ? 6'd0 : hour_q + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLOCK;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
      pos_q   <= POS_SEC;
    end else begin
      case (state_q)
        ST_CLOCK: begin
          // Tick and mode press are independent here: both can land on one edge.
          if (bus.i_tick) begin
            sec_q <= sec_d;
            if (sec_wrap) begin
              min_q <= min_d;
              if (min_wrap) hour_q <= hour_d;
            end
          end
          if (mode_p) begin
            state_q <= ST_SETUP;
            pos_q   <= POS_SEC;
          end
        end
        ST_SETUP: begin
          // Priority mode > pos > inc; lower-priority presses on the same edge are lost.
          if (mode_p) begin
            state_q <= ST_CLOCK;
          end else if (pos_p) begin
            pos_q <= (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
          end else if (inc_p) begin
            case (pos_q)
              POS_SEC:  sec_q  <= sec_d;
              POS_MIN:  min_q  <= min_d;
              POS_HOUR: hour_q <= hour_d;
              default:  ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.o_sec  = sec_q;
  assign bus.o_min  = min_q;
  assign bus.o_hour = hour_q;
  assign bus.o_mode = (state_q == ST_SETUP);
  assign bus.o_pos  = pos_q;

  always_comb begin
    bus.o_six_dp = 6'b000000;
    if (state_q == ST_SETUP) begin
      case (pos_q)
        POS_SEC:  bus.o_six_dp = 6'b000011;
        POS_MIN:  bus.o_six_dp = 6'b001100;
        POS_HOUR: bus.o_six_dp = 6'b110000;
        default:  bus.o_six_dp = 6'b000000;
      endcase
    end
  end
endmodule
